imem_fetch_ctrl: RTL and testbench
==================================

// Module: imem_fetch_ctrl
//
// PURPOSE
//  Instruction-fetch initiator driving the single-port instruction memory macro port (ena/wea/addra/dina/douta).
//  Memory read latency is 1 cycle. The memory clears douta to 0 on any cycle with ena low, so every response is captured the cycle it returns.
//  Owns the PC. Issues sequential word reads. Buffers returned words in a small fetch queue.
//  Presents {pc, instr} to decode over a valid/ready handshake. Handles branch redirects, including in-flight kill.
//
// PARAMETERS
//  ADDR_WIDTH  32  byte-address width of PC and mem_addra
//  DATA_WIDTH  32  instruction word width
//  RESET_PC    0   PC loaded on reset; must be word aligned
//  FQ_DEPTH    2   fetch-queue entries, power of 2, >=2
//
// PORTS
//  clka            in   1           clock
//  rsta            in   1           reset, asynchronous, active-high
//  fetch_en        in   1           permit new memory requests
//  redirect_valid  in   1           flush and restart at redirect_pc
//  redirect_pc     in   ADDR_WIDTH  new fetch byte address; bits[1:0] are ignored (forced 0)
//  mem_ena         out  1           memory enable (request strobe)
//  mem_wea         out  1           constant 0 (read-only initiator)
//  mem_addra       out  ADDR_WIDTH  request byte address
//  mem_dina        out  DATA_WIDTH  constant 0
//  mem_douta       in   DATA_WIDTH  read data, valid 1 cycle after request
//  if_valid        out  1           fetch-queue head valid
//  if_ready        in   1           decode accepts head
//  if_pc           out  ADDR_WIDTH  PC of head entry
//  if_instr        out  DATA_WIDTH  instruction of head entry
//  busy            out  1           request in flight or queue non-empty
//
// BEHAVIOUR
//  - Reset (async, any time): pc=RESET_PC; queue emptied; inflight=0; state=IDLE.
//    All outputs 0 during reset, and stay 0 until the first issue. Any response pending at reset is lost.
//  - pop = if_valid & if_ready.
//  - issue_ok = fetch_en & (fq_count + inflight - pop < FQ_DEPTH).
//    This credit check guarantees a queue slot for every response. At steady state it sustains 1 fetch/cycle.
//  - Issue cycle N: mem_ena=1, mem_addra=pc, pc<=pc+4 (mod 2^ADDR_WIDTH, wraps silently), inflight<=1, req_pc<=pc.
//  - Response cycle N+1: mem_douta is pushed as {req_pc, mem_douta}. if_valid rises in cycle N+2.
//    Issue-to-if_valid latency is 2 cycles.
//  - mem_ena=0 whenever no issue occurs. The bubble returns 0 from memory and is never pushed.
//  - Queue: registered head outputs, in-order. Push and pop in the same cycle are legal at any occupancy. No push while full is possible, by the credit rule.
//  - Redirect (highest priority, single cycle R):
//    - queue flushed (fq_count<=0);
//    - response arriving in R is discarded (not pushed);
//    - if fetch_en, issue at redirect_pc&~3 in R (mem_addra bypasses to redirect_pc), pc<=redirect_pc+4; else pc<=redirect_pc.
//    - A pop coinciding with R is a completed transfer. The consumer driving redirect ignores it.
//  - FSM (tracks busy/flow only; does not gate the datapath beyond issue):
//    - IDLE: fetch_en=0, nothing outstanding. -> RUN when fetch_en=1.
//    - RUN: issuing per credits. -> DRAIN when fetch_en falls with inflight|fq_count!=0. -> IDLE when fetch_en falls and nothing is outstanding.
//    - DRAIN: no issue. In-flight response still queued. -> IDLE when the queue is empty and inflight=0. -> RUN when fetch_en=1.
//  - busy = inflight | (fq_count!=0).
//  - Stall: if_ready=0 holds if_valid/if_pc/if_instr stable. Issue stops once credits are exhausted and never drops a response.
//
// STRUCTURE
//  - Shared package imem_pkg:
//    - fetch_state_e {IDLE, RUN, DRAIN};
//    - localparam PC_STEP=4;
//    - fetch_entry_t {pc, instr} typedef.
//  - Sub-module imem_fetch_fifo: synchronous FIFO of fetch_entry_t, FQ_DEPTH deep, with flush, count, and registered head.
//  - Top level holds the PC, inflight/req_pc registers, credit logic, and the FSM.
//
// TESTING
//  1. Reset, fetch_en=1, if_ready=1, memory words 0x13,0x93,0x113...
//     -> mem_addra 0,4,8 on consecutive cycles; if_valid from cycle 2; if_pc 0,4,8 with matching instr.
//  2. Steady stream, then if_ready=0 for 5 cycles.
//     -> at most FQ_DEPTH entries held; mem_ena drops; head is stable. After release, order continues with no gap or duplicate.
//  3. redirect_valid with redirect_pc=0x100 while a response for 0x20 is in flight.
//     -> 0x20 word never appears; queue emptied; mem_addra=0x100 in R; next if_pc=0x100.
//  4. redirect_pc=0x203 -> fetch at 0x200; if_pc=0x200.
//  5. fetch_en falls with 1 in flight and 1 queued.
//     -> state DRAIN, both delivered, then IDLE with busy=0.
//  6. rsta pulsed mid-stream -> all outputs 0 immediately; restart at RESET_PC; no stale entry delivered.
//     Also start at pc=0xFFFFFFFC -> next request wraps to 0x0.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types for the instruction-fetch slice: FSM states, PC step and the
// {pc, instr} entry carried through the fetch queue.
package imem_pkg;

  // Entry field widths; they match the fetch controller's default widths.
  localparam int ENTRY_ADDR_W = 32;
  localparam int ENTRY_DATA_W = 32;
  localparam int PC_STEP      = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ENTRY_ADDR_W-1:0] pc;
    logic [ENTRY_DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/imem_fetch_fifo.sv
// In-order fetch queue with flush, occupancy count and a head that reads 0
// whenever the queue is empty.
module imem_fetch_fifo
  import imem_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic         clka,
  input  logic         rsta,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output logic         head_valid,
  output fetch_entry_t head_data,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_pop;

  assign head_valid = (count_q != '0);
  assign do_pop     = pop & head_valid;
  assign count      = count_q;
  assign head_data  = head_valid ? mem_q[rd_ptr_q] : '0;

  // NOTE: storage has no reset; the head is masked to 0 while empty instead.
  always_ff @(posedge clka) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)   wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch initiator: owns the PC, issues credit-limited sequential
// reads to a 1-cycle memory, queues responses and handles branch redirects.
module imem_fetch_ctrl
  import imem_pkg::*;
#(
  parameter int ADDR_WIDTH          = ENTRY_ADDR_W,
  parameter int DATA_WIDTH          = ENTRY_DATA_W,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int FQ_DEPTH            = 2
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic                  fetch_en,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  mem_ena,
  output logic                  mem_wea,
  output logic [ADDR_WIDTH-1:0] mem_addra,
  output logic [DATA_WIDTH-1:0] mem_dina,
  input  logic [DATA_WIDTH-1:0] mem_douta,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic [DATA_WIDTH-1:0] if_instr,
  output logic                  busy
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;
  localparam int OW = CW + 1;
  localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(PC_STEP);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

  logic [ADDR_WIDTH-1:0] pc_q, req_pc_q, redirect_base, issue_addr;
  logic                  inflight_q;
  logic [CW-1:0]         fq_count;
  logic [OW-1:0]         occupancy;
  logic                  pop, credit_ok, issue, push;
  fetch_entry_t          push_data, head_data;
  fetch_state_e          state_q, state_d;

  assign pop           = if_valid & if_ready;
  assign occupancy     = OW'(fq_count) + OW'(inflight_q) - OW'(pop);
  assign credit_ok     = (occupancy < OW'(FQ_DEPTH));
  assign redirect_base = redirect_pc & ALIGN_MASK;
  assign issue_addr    = redirect_valid ? redirect_base : pc_q;

  // A redirect flushes the queue and kills the in-flight word, so it always has a free slot.
  // Reset is folded in so the strobe stays low while rsta is held.
  assign issue = ~rsta & fetch_en & (redirect_valid | credit_ok);

  assign mem_ena   = issue;
  assign mem_addra = issue ? issue_addr : '0;
  assign mem_wea   = 1'b0;
  assign mem_dina  = '0;

  assign push      = inflight_q & ~redirect_valid;
  assign push_data = '{pc: req_pc_q, instr: mem_douta};

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) req_pc_q <= issue_addr;
      if (redirect_valid)
        pc_q <= fetch_en ? redirect_base + STEP : redirect_base;
      else if (issue)
        pc_q <= pc_q + STEP;
    end
  end

  imem_fetch_fifo #(.DEPTH(FQ_DEPTH)) u_fifo (
    .clka       (clka),
    .rsta       (rsta),
    .flush      (redirect_valid),
    .push       (push),
    .push_data  (push_data),
    .pop        (if_ready),
    .head_valid (if_valid),
    .head_data  (head_data),
    .count      (fq_count)
  );

  assign if_pc    = head_data.pc;
  assign if_instr = head_data.instr;
  assign busy     = inflight_q | (fq_count != '0);

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // NOTE: next state defaults to the current state first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fetch_en) state_d = RUN;
      RUN:     if (!fetch_en) state_d = busy ? DRAIN : IDLE;
      DRAIN: begin
        if (fetch_en)  state_d = RUN;
        else if (!busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: behavioural 1-cycle memory, a
// scoreboard of expected {pc, instr} entries and one task per scenario.
module tb_imem_fetch_ctrl;
  import imem_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int FQ_DEPTH = 2;
  localparam logic [AW-1:0] RESET_PC = '0;

  logic          clka = 1'b0;
  logic          rsta = 1'b1;
  logic          fetch_en = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          mem_ena, mem_wea;
  logic [AW-1:0] mem_addra;
  logic [DW-1:0] mem_dina;
  logic [DW-1:0] mem_douta;
  logic          if_valid;
  logic          if_ready = 1'b1;
  logic [AW-1:0] if_pc;
  logic [DW-1:0] if_instr;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  fetch_entry_t  sb[$];
  logic [AW-1:0] model_pc = RESET_PC;
  int            pop_count = 0;
  logic [AW-1:0] last_pop_pc = '0;
  bit            seen_20 = 1'b0;

  imem_fetch_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RESET_PC   (RESET_PC),
    .FQ_DEPTH   (FQ_DEPTH)
  ) dut (
    .clka           (clka),
    .rsta           (rsta),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_ena        (mem_ena),
    .mem_wea        (mem_wea),
    .mem_addra      (mem_addra),
    .mem_dina       (mem_dina),
    .mem_douta      (mem_douta),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .busy           (busy)
  );

  always #5 clka = ~clka;

  // Memory content: 0x13, 0x93, 0x113, ... at byte addresses 0, 4, 8, ...
  function automatic logic [DW-1:0] word_at(input logic [AW-1:0] a);
    return (a << 5) + 32'h13;
  endfunction

  always @(posedge clka or posedge rsta) begin
    if (rsta)         mem_douta <= '0;
    else if (mem_ena) mem_douta <= word_at(mem_addra);
    else              mem_douta <= '0;
  end

  // Monitor: complete pops against the scoreboard, then apply redirect, then log issues.
  always @(negedge clka) begin
    if (!rsta) begin
      if (if_valid && if_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL pop_unexpected: got pc=%h instr=%h, expected no entry", if_pc, if_instr);
        end else begin
          fetch_entry_t exp_e;
          exp_e = sb.pop_front();
          if (if_pc !== exp_e.pc || if_instr !== exp_e.instr) begin
            failures++;
            $display("FAIL pop_order: got pc=%h instr=%h, expected pc=%h instr=%h",
                     if_pc, if_instr, exp_e.pc, exp_e.instr);
          end
        end
        pop_count++;
        last_pop_pc = if_pc;
        if (if_pc == 32'h20) seen_20 = 1'b1;
      end
      if (redirect_valid) begin
        sb.delete();
        model_pc = redirect_pc & ~32'h3;
        checks++;
        if (mem_ena !== fetch_en) begin
          failures++;
          $display("FAIL redirect_issue: got mem_ena=%b, expected %b", mem_ena, fetch_en);
        end
      end
      if (mem_ena) begin
        checks++;
        if (mem_addra !== model_pc) begin
          failures++;
          $display("FAIL issue_addr: got mem_addra=%h, expected %h", mem_addra, model_pc);
        end
        sb.push_back('{pc: model_pc, instr: word_at(model_pc)});
        model_pc = model_pc + 32'd4;
      end
      checks++;
      if (sb.size() > FQ_DEPTH) begin
        failures++;
        $display("FAIL credit: got %0d outstanding entries, expected at most %0d", sb.size(), FQ_DEPTH);
      end
    end
  end

  task automatic do_reset();
    rsta = 1'b1;
    fetch_en = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    if_ready = 1'b1;
    sb.delete();
    model_pc = RESET_PC;
    repeat (2) @(posedge clka);
    #1 rsta = 1'b0;
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if ({mem_ena, mem_wea, mem_addra, mem_dina, if_valid, if_pc, if_instr, busy} !== '0) begin
      failures++;
      $display("FAIL %s: got ena=%b wea=%b addr=%h dina=%h valid=%b pc=%h instr=%h busy=%b, expected all 0",
               name, mem_ena, mem_wea, mem_addra, mem_dina, if_valid, if_pc, if_instr, busy);
    end
  endtask

  task automatic wait_pop(input logic [AW-1:0] exp_pc, input string name);
    int  start;
    bit  got;
    start = pop_count;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clka);
      if (pop_count != start) got = 1'b1;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s: got no pop within 40 cycles, expected pc=%h", name, exp_pc);
    end else if (last_pop_pc !== exp_pc) begin
      failures++;
      $display("FAIL %s: got pc=%h, expected %h", name, last_pop_pc, exp_pc);
    end
  endtask

  task automatic test_reset();
    rsta = 1'b1;
    #1 check_outputs_zero("reset_hold");
    do_reset();
    @(negedge clka);
    check_outputs_zero("post_reset_idle");
    checks++;
    if (dut.state_q !== IDLE) begin
      failures++;
      $display("FAIL reset_state: got %0d, expected IDLE", dut.state_q);
    end
  endtask

  task automatic test_stream();
    logic [AW-1:0] exp_addr [3];
    do_reset();
    exp_addr[0] = 32'h0; exp_addr[1] = 32'h4; exp_addr[2] = 32'h8;
    @(posedge clka);
    #1 fetch_en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clka);
      checks++;
      if (mem_ena !== 1'b1 || mem_addra !== exp_addr[c]) begin
        failures++;
        $display("FAIL stream_issue%0d: got ena=%b addr=%h, expected ena=1 addr=%h", c, mem_ena, mem_addra, exp_addr[c]);
      end
      checks++;
      if (if_valid !== (c == 2)) begin
        failures++;
        $display("FAIL stream_latency%0d: got if_valid=%b, expected %b", c, if_valid, (c == 2));
      end
    end
    checks++;
    if (if_pc !== 32'h0 || if_instr !== 32'h13) begin
      failures++;
      $display("FAIL stream_first: got pc=%h instr=%h, expected pc=0 instr=13", if_pc, if_instr);
    end
    repeat (6) @(posedge clka);
  endtask

  task automatic test_stall();
    logic [AW-1:0] held_pc;
    logic [DW-1:0] held_instr;
    @(posedge clka);
    #1 if_ready = 1'b0;
    @(negedge clka);
    held_pc = if_pc;
    held_instr = if_instr;
    for (int c = 0; c < 4; c++) begin
      @(negedge clka);
      checks++;
      if (if_valid !== 1'b1 || if_pc !== held_pc || if_instr !== held_instr) begin
        failures++;
        $display("FAIL stall_hold%0d: got valid=%b pc=%h instr=%h, expected valid=1 pc=%h instr=%h",
                 c, if_valid, if_pc, if_instr, held_pc, held_instr);
      end
    end
    checks++;
    if (mem_ena !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL stall_no_issue: got mem_ena=%b busy=%b, expected mem_ena=0 busy=1", mem_ena, busy);
    end
    @(posedge clka);
    #1 if_ready = 1'b1;
    repeat (8) @(posedge clka);
  endtask

  task automatic test_redirect();
    bit found;
    do_reset();
    seen_20 = 1'b0;
    found = 1'b0;
    @(posedge clka);
    #1 fetch_en = 1'b1;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clka);
      if (mem_ena && mem_addra == 32'h20) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL redirect_setup: got no issue of 0x20 within 30 cycles, expected one");
    end
    @(posedge clka);
    #1 redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    @(negedge clka);
    checks++;
    if (mem_ena !== 1'b1 || mem_addra !== 32'h100) begin
      failures++;
      $display("FAIL redirect_addr: got ena=%b addr=%h, expected ena=1 addr=00000100", mem_ena, mem_addra);
    end
    @(posedge clka);
    #1 redirect_valid = 1'b0;
    @(negedge clka);
    checks++;
    if (if_valid !== 1'b0) begin
      failures++;
      $display("FAIL redirect_flush: got if_valid=%b, expected 0", if_valid);
    end
    wait_pop(32'h100, "redirect_target");
    checks++;
    if (seen_20) begin
      failures++;
      $display("FAIL redirect_kill: got killed word 0x20 delivered, expected none");
    end
    repeat (4) @(posedge clka);
  endtask

  task automatic test_redirect_unaligned();
    @(posedge clka);
    #1 redirect_valid = 1'b1;
    redirect_pc = 32'h203;
    @(negedge clka);
    checks++;
    if (mem_addra !== 32'h200) begin
      failures++;
      $display("FAIL unaligned_addr: got addr=%h, expected 00000200", mem_addra);
    end
    @(posedge clka);
    #1 redirect_valid = 1'b0;
    wait_pop(32'h200, "unaligned_pop");
    repeat (3) @(posedge clka);
  endtask

  task automatic test_drain();
    int start;
    bit idle;
    do_reset();
    if_ready = 1'b0;
    @(posedge clka);
    #1 fetch_en = 1'b1;
    @(posedge clka);
    @(posedge clka);
    #1 fetch_en = 1'b0;
    start = pop_count;
    @(posedge clka);
    #1;
    checks++;
    if (dut.state_q !== DRAIN || busy !== 1'b1) begin
      failures++;
      $display("FAIL drain_enter: got state=%0d busy=%b, expected DRAIN busy=1", dut.state_q, busy);
    end
    if_ready = 1'b1;
    idle = 1'b0;
    for (int c = 0; c < 20 && !idle; c++) begin
      @(posedge clka);
      #1 if (!busy) idle = 1'b1;
    end
    @(posedge clka);
    #1;
    checks++;
    if (!idle || dut.state_q !== IDLE || busy !== 1'b0) begin
      failures++;
      $display("FAIL drain_exit: got idle_seen=%b state=%0d busy=%b, expected IDLE busy=0", idle, dut.state_q, busy);
    end
    checks++;
    if (pop_count - start != 2 || sb.size() != 0) begin
      failures++;
      $display("FAIL drain_delivered: got %0d pops %0d left, expected 2 pops 0 left", pop_count - start, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(posedge clka);
    #1 fetch_en = 1'b1;
    repeat (6) @(posedge clka);
    #1 rsta = 1'b1;
    #1 check_outputs_zero("reset_mid");
    sb.delete();
    model_pc = RESET_PC;
    @(posedge clka);
    #1 rsta = 1'b0;
    wait_pop(RESET_PC, "reset_restart");
  endtask

  task automatic test_wrap();
    @(posedge clka);
    #1 redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    @(posedge clka);
    #1 redirect_valid = 1'b0;
    wait_pop(32'hFFFF_FFFC, "wrap_last");
    wait_pop(32'h0, "wrap_zero");
    @(posedge clka);
    #1 fetch_en = 1'b0;
    repeat (6) @(posedge clka);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_unaligned();
    test_drain();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
